alu_datapath_pipe: RTL

Parametrised successor to the lab 16-bit register-file + ALU datapath. Two-stage pipeline: a decode register, then a combined execute/writeback stage that updates the register file and output register. Adds valid/ready handshakes on both the instruction and result sides, so results can be backpressured. Adds registered status flags, a retired-result counter, and an init path that loads DataInit through the same pipeline, so ordering with compute instructions is preserved.

---
 rtl/alu_datapath_pipe.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/alu_datapath_pipe.sv
// Two-stage register-file + ALU datapath: a decode register followed by an
// execute/writeback stage, with valid/ready handshakes on both sides.
module alu_datapath_pipe #(
    parameter int DATA_W = 16,
    parameter int RA_W   = 4,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4+3*RA_W-1:0]   instr,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic                  init_sel,
    input  logic [DATA_W-1:0]     data_init,
    output logic [DATA_W-1:0]     alu_out,
    output logic [RA_W-1:0]       out_rd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3:0]            flags,
    output logic [CNT_W-1:0]      retired
);

    localparam int INSTR_W = 4 + 3*RA_W;
    localparam int NREG    = 1 << RA_W;
    localparam int SH_W    = $clog2(DATA_W);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_ADDI = 4'd8;
    localparam logic [3:0] OP_SLT  = 4'd9;
    localparam logic [3:0] OP_MOV  = 4'd10;

    logic                 s1_valid_q, s1_valid_d;
    logic [INSTR_W-1:0]   s1_instr_q, s1_instr_d;
    logic                 s1_sel_q, s1_sel_d;
    logic [DATA_W-1:0]    s1_data_q, s1_data_d;
    logic [DATA_W-1:0]    regs_q [NREG];
    logic [DATA_W-1:0]    regs_d [NREG];
    logic [DATA_W-1:0]    alu_out_q, alu_out_d;
    logic [RA_W-1:0]      out_rd_q, out_rd_d;
    logic                 out_valid_q, out_valid_d;
    logic [3:0]           flags_q, flags_d;
    logic [CNT_W-1:0]     retired_q, retired_d;

    logic [3:0]           op_s;
    logic [RA_W-1:0]      rd_s, rs1_s, rs2_s;
    logic [DATA_W-1:0]    a_s, b_s, imm_s, res_s, wdata_s;
    logic [DATA_W:0]      sum_s, diff_s;
    logic                 carry_s, ovf_s, produce_s, init_s, wr_s;
    logic                 stall_s, advance_s, accept_s, handshake_s;

    assign op_s  = s1_instr_q[INSTR_W-1 -: 4];
    assign rd_s  = s1_instr_q[3*RA_W-1 -: RA_W];
    assign rs1_s = s1_instr_q[2*RA_W-1 -: RA_W];
    assign rs2_s = s1_instr_q[RA_W-1:0];
    assign a_s   = regs_q[rs1_s];
    assign b_s   = regs_q[rs2_s];
    assign imm_s = {{(DATA_W-RA_W){1'b0}}, rs2_s};

    assign stall_s     = out_valid_q & ~out_ready;
    assign advance_s   = s1_valid_q & ~stall_s;
    assign instr_ready = reset | ~s1_valid_q | ~stall_s;
    assign accept_s    = instr_valid & instr_ready;
    assign handshake_s = out_valid_q & out_ready;

    // ALU: result, carry/overflow and whether the opcode produces a result
    always_comb begin
        sum_s     = {1'b0, a_s} + {1'b0, (op_s == OP_ADDI) ? imm_s : b_s};
        diff_s    = {1'b0, a_s} - {1'b0, b_s};
        res_s     = {DATA_W{1'b0}};
        carry_s   = 1'b0;
        ovf_s     = 1'b0;
        produce_s = 1'b1;
        case (op_s)
            OP_ADD, OP_ADDI: begin
                res_s   = sum_s[DATA_W-1:0];
                carry_s = sum_s[DATA_W];
                ovf_s   = (a_s[DATA_W-1] == ((op_s == OP_ADDI) ? imm_s[DATA_W-1] : b_s[DATA_W-1]))
                          && (sum_s[DATA_W-1] != a_s[DATA_W-1]);
            end
            OP_SUB: begin
                res_s   = diff_s[DATA_W-1:0];
                carry_s = ~diff_s[DATA_W];
                ovf_s   = (a_s[DATA_W-1] != b_s[DATA_W-1]) && (diff_s[DATA_W-1] != a_s[DATA_W-1]);
            end
            OP_AND: res_s = a_s & b_s;
            OP_OR:  res_s = a_s | b_s;
            OP_XOR: res_s = a_s ^ b_s;
            OP_SLL: res_s = a_s << b_s[SH_W-1:0];
            OP_SRL: res_s = a_s >> b_s[SH_W-1:0];
            OP_SRA: res_s = $unsigned($signed(a_s) >>> b_s[SH_W-1:0]);
            OP_SLT: begin
                res_s   = {{(DATA_W-1){1'b0}}, ($signed(a_s) < $signed(b_s))};
                carry_s = ~diff_s[DATA_W];
            end
            OP_MOV: res_s = a_s;
            default: produce_s = 1'b0;
        endcase
        init_s  = ~s1_sel_q;
        wr_s    = init_s | produce_s;
        wdata_s = init_s ? s1_data_q : res_s;
    end

    // Next-state for pipeline registers, register file, outputs and counter
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_instr_d  = s1_instr_q;
        s1_sel_d    = s1_sel_q;
        s1_data_d   = s1_data_q;
        regs_d      = regs_q;
        alu_out_d   = alu_out_q;
        out_rd_d    = out_rd_q;
        out_valid_d = out_valid_q;
        flags_d     = flags_q;
        retired_d   = retired_q + {{(CNT_W-1){1'b0}}, handshake_s};

        if (accept_s) begin
            s1_valid_d = 1'b1;
            s1_instr_d = instr;
            s1_sel_d   = init_sel;
            s1_data_d  = data_init;
        end else if (advance_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end

        if (advance_s && wr_s) begin
            regs_d[rd_s] = wdata_s;
            alu_out_d    = wdata_s;
            out_rd_d     = rd_s;
            out_valid_d  = 1'b1;
            if (!init_s) begin
                flags_d = {(res_s == {DATA_W{1'b0}}), res_s[DATA_W-1], carry_s, ovf_s};
            end else begin
                flags_d = flags_q;
            end
        end else if (handshake_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_instr_q  <= '0;
            s1_sel_q    <= 1'b0;
            s1_data_q   <= '0;
            alu_out_q   <= '0;
            out_rd_q    <= '0;
            out_valid_q <= 1'b0;
            flags_q     <= 4'b0000;
            retired_q   <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_instr_q  <= s1_instr_d;
            s1_sel_q    <= s1_sel_d;
            s1_data_q   <= s1_data_d;
            alu_out_q   <= alu_out_d;
            out_rd_q    <= out_rd_d;
            out_valid_q <= out_valid_d;
            flags_q     <= flags_d;
            retired_q   <= retired_d;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign alu_out   = alu_out_q;
    assign out_rd    = out_rd_q;
    assign out_valid = out_valid_q;
    assign flags     = flags_q;
    assign retired   = retired_q;

endmodule
